// File: rtl/dec_8b10b_pkg.sv
// Shared constants, sync-FSM states and small helpers for the 8b/10b receive decoder.
// Optional error counter in the top level is enabled by defining DEC_ERR_CNT_EN.
package dec_8b10b_pkg;

  localparam logic [9:0] K28_5_RDN  = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP  = 10'b1100000101;

  localparam logic [5:0] K28_6B_RDN = 6'b001111;
  localparam logic [5:0] K28_6B_RDP = 6'b110000;
  localparam logic [4:0] K28_X      = 5'd28;

  localparam logic [7:0] K28_1_BYTE = 8'h3C;
  localparam logic [7:0] K28_5_BYTE = 8'hBC;
  localparam logic [7:0] K28_7_BYTE = 8'hFC;

  typedef enum logic [1:0] {LOS, ACQ, SYNC} sync_state_e;

  function automatic logic is_comma(input logic [7:0] d, input logic k);
    return k && (d == K28_1_BYTE || d == K28_5_BYTE || d == K28_7_BYTE);
  endfunction

  function automatic logic [3:0] ones6(input logic [5:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 6; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/dec_8b10b_lut.sv
// Combinational 10b->8b decode with table membership, K detection and
// sub-block running-disparity checking against the supplied running disparity.
module dec_8b10b_lut
  import dec_8b10b_pkg::*;
(
  input  logic [9:0] code_in,
  input  logic       rd_in,
  output logic [7:0] data,
  output logic       k,
  output logic       code_err,
  output logic       disp_err,
  output logic       rd_next
);

  logic [5:0] s6;
  logic [3:0] s4;
  logic [4:0] x;
  logic [2:0] y, y_k;
  logic       v6, k28, v4, a7, r4_def, r4;
  logic [3:0] n6, n4, n10;
  logic       pos6, neg6, pos4, neg4, e6, compat;
  logic       alt_n, alt_p, kx7, valid;
  logic       rd6, rd4, err6, err4;

  assign s6  = code_in[9:4];
  assign s4  = code_in[3:0];
  assign n6  = ones6(s6);
  assign n4  = ones6({2'b00, s4});
  assign n10 = n6 + n4;

  always_comb begin
    v6  = 1'b1;
    k28 = 1'b0;
    x   = 5'd0;
    case (s6)
      6'b100111, 6'b011000: x = 5'd0;
      6'b011101, 6'b100010: x = 5'd1;
      6'b101101, 6'b010010: x = 5'd2;
      6'b110001:            x = 5'd3;
      6'b110101, 6'b001010: x = 5'd4;
      6'b101001:            x = 5'd5;
      6'b011001:            x = 5'd6;
      6'b111000, 6'b000111: x = 5'd7;
      6'b111001, 6'b000110: x = 5'd8;
      6'b100101:            x = 5'd9;
      6'b010101:            x = 5'd10;
      6'b110100:            x = 5'd11;
      6'b001101:            x = 5'd12;
      6'b101100:            x = 5'd13;
      6'b011100:            x = 5'd14;
      6'b010111, 6'b101000: x = 5'd15;
      6'b011011, 6'b100100: x = 5'd16;
      6'b100011:            x = 5'd17;
      6'b010011:            x = 5'd18;
      6'b110010:            x = 5'd19;
      6'b001011:            x = 5'd20;
      6'b101010:            x = 5'd21;
      6'b011010:            x = 5'd22;
      6'b111010, 6'b000101: x = 5'd23;
      6'b110011, 6'b001100: x = 5'd24;
      6'b100110:            x = 5'd25;
      6'b010110:            x = 5'd26;
      6'b110110, 6'b001001: x = 5'd27;
      6'b001110:            x = 5'd28;
      6'b101110, 6'b010001: x = 5'd29;
      6'b011110, 6'b100001: x = 5'd30;
      6'b101011, 6'b010100: x = 5'd31;
      K28_6B_RDN, K28_6B_RDP: begin x = K28_X; k28 = 1'b1; v6 = 1'b0; end
      default:              v6 = 1'b0;
    endcase
  end

  // r4 is the disparity the 4b form must follow: 0 for RD- forms, 1 for RD+ forms
  always_comb begin
    v4     = 1'b1;
    a7     = 1'b0;
    r4_def = 1'b1;
    r4     = 1'b0;
    y      = 3'd0;
    case (s4)
      4'b1011: begin y = 3'd0; r4 = 1'b0; end
      4'b0100: begin y = 3'd0; r4 = 1'b1; end
      4'b1001: begin y = 3'd1; r4_def = 1'b0; end
      4'b0101: begin y = 3'd2; r4_def = 1'b0; end
      4'b1100: begin y = 3'd3; r4 = 1'b0; end
      4'b0011: begin y = 3'd3; r4 = 1'b1; end
      4'b1101: begin y = 3'd4; r4 = 1'b0; end
      4'b0010: begin y = 3'd4; r4 = 1'b1; end
      4'b1010: begin y = 3'd5; r4_def = 1'b0; end
      4'b0110: begin y = 3'd6; r4_def = 1'b0; end
      4'b1110: begin y = 3'd7; r4 = 1'b0; end
      4'b0001: begin y = 3'd7; r4 = 1'b1; end
      4'b0111: begin y = 3'd7; r4 = 1'b0; a7 = 1'b1; end
      4'b1000: begin y = 3'd7; r4 = 1'b1; a7 = 1'b1; end
      default: begin v4 = 1'b0; r4_def = 1'b0; end
    endcase
  end

  assign pos6   = (n6 > 4'd3) || (s6 == 6'b000111);
  assign neg6   = (n6 < 4'd3) || (s6 == 6'b111000);
  assign pos4   = (n4 > 4'd2) || (s4 == 4'b0011);
  assign neg4   = (n4 < 4'd2) || (s4 == 4'b1100);
  assign e6     = pos6 ? 1'b1 : (neg6 ? 1'b0 : r4);
  assign compat = !r4_def || (!pos6 && !neg6) || (pos6 && r4) || (neg6 && !r4);
  // Balanced K28 4b sub-blocks after RD- are the complements of the D forms
  assign y_k    = (!e6 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6)) ? (3'd7 - y) : y;
  assign alt_n  = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
  assign alt_p  = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
  assign kx7    = (x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30);

  always_comb begin
    valid = 1'b0;
    k     = 1'b0;
    data  = 8'h00;
    if (k28 && v4 && compat && (y != 3'd7 || a7)) begin
      valid = 1'b1;
      k     = 1'b1;
      data  = {y_k, K28_X};
    end else if (v6 && v4 && compat) begin
      if (a7) begin
        if (kx7) begin
          valid = 1'b1;
          k     = 1'b1;
          data  = {3'd7, x};
        end else if ((!r4 && alt_n) || (r4 && alt_p)) begin
          valid = 1'b1;
          data  = {3'd7, x};
        end
      end else if (y != 3'd7 || !((!r4 && alt_n) || (r4 && alt_p))) begin
        valid = 1'b1;
        data  = {y, x};
      end
    end
  end

  always_comb begin
    err6 = 1'b0;
    rd6  = rd_in;
    if (pos6) begin
      err6 = (s6 == 6'b000111) ? !rd_in : rd_in;
      rd6  = 1'b1;
    end else if (neg6) begin
      err6 = (s6 == 6'b111000) ? rd_in : !rd_in;
      rd6  = 1'b0;
    end
    err4 = 1'b0;
    rd4  = rd6;
    if (pos4) begin
      err4 = (s4 == 4'b0011) ? !rd6 : rd6;
      rd4  = 1'b1;
    end else if (neg4) begin
      err4 = (s4 == 4'b1100) ? rd6 : !rd6;
      rd4  = 1'b0;
    end
  end

  assign code_err = !valid;
  assign disp_err = err6 | err4;
  assign rd_next  = valid ? rd4 :
                    (n10 > 4'd5) ? 1'b1 :
                    (n10 < 4'd5) ? 1'b0 : rd_in;

endmodule

// File: rtl/dec_8b10b_rx.sv
// 8b/10b receiver: registered decode, running-disparity tracking and comma-based link sync.
// Define DEC_ERR_CNT_EN to build the saturating bad-word counter on err_count.
module dec_8b10b_rx
  import dec_8b10b_pkg::*;
#(
  parameter int COMMA_CNT = 3,
  parameter int ERR_LIMIT = 4,
  parameter int GOOD_RUN  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  code_in,
  input  logic        code_valid,
  output logic [7:0]  data_out,
  output logic        k_out,
  output logic        data_valid,
  output logic        code_err,
  output logic        disp_err,
  output logic        rd_out,
  output logic        sync,
  output logic [15:0] err_count
);

  localparam logic [7:0] COMMA_N = 8'(COMMA_CNT);
  localparam logic [7:0] ERR_N   = 8'(ERR_LIMIT);
  localparam logic [7:0] GOOD_N  = 8'(GOOD_RUN);

  logic [7:0]  lut_data;
  logic        lut_k, lut_cerr, lut_derr, lut_rd;
  logic        bad, comma;
  sync_state_e state_q, state_d;
  logic [7:0]  comma_cnt_q, comma_cnt_d, err_cnt_q, err_cnt_d, good_cnt_q, good_cnt_d;
  logic [7:0]  comma_inc, err_inc, good_inc;
  logic [7:0]  data_q;
  logic        k_q, dv_q, cerr_q, derr_q, rd_q, sync_q;

  dec_8b10b_lut u_lut (
    .code_in  (code_in),
    .rd_in    (rd_q),
    .data     (lut_data),
    .k        (lut_k),
    .code_err (lut_cerr),
    .disp_err (lut_derr),
    .rd_next  (lut_rd)
  );

  assign bad       = lut_cerr | lut_derr;
  assign comma     = !bad && is_comma(lut_data, lut_k);
  assign comma_inc = comma_cnt_q + 8'd1;
  assign err_inc   = err_cnt_q + 8'd1;
  assign good_inc  = good_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    good_cnt_d  = good_cnt_q;
    if (code_valid) begin
      case (state_q)
        LOS: if (comma) begin
          comma_cnt_d = 8'd1;
          err_cnt_d   = 8'd0;
          good_cnt_d  = 8'd0;
          state_d     = (8'd1 >= COMMA_N) ? SYNC : ACQ;
        end
        ACQ: if (bad) begin
          state_d     = LOS;
          comma_cnt_d = 8'd0;
        end else if (comma) begin
          comma_cnt_d = comma_inc;
          if (comma_inc >= COMMA_N) begin
            state_d    = SYNC;
            err_cnt_d  = 8'd0;
            good_cnt_d = 8'd0;
          end
        end
        SYNC: if (bad) begin
          good_cnt_d = 8'd0;
          err_cnt_d  = err_inc;
          if (err_inc >= ERR_N) begin
            state_d     = LOS;
            err_cnt_d   = 8'd0;
            comma_cnt_d = 8'd0;
          end
        end else if (good_inc >= GOOD_N) begin
          good_cnt_d = 8'd0;
          err_cnt_d  = (err_cnt_q != 8'd0) ? err_cnt_q - 8'd1 : 8'd0;
        end else begin
          good_cnt_d = good_inc;
        end
        default: state_d = LOS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOS;
      comma_cnt_q <= 8'd0;
      err_cnt_q   <= 8'd0;
      good_cnt_q  <= 8'd0;
      data_q      <= 8'h00;
      k_q         <= 1'b0;
      dv_q        <= 1'b0;
      cerr_q      <= 1'b0;
      derr_q      <= 1'b0;
      rd_q        <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      good_cnt_q  <= good_cnt_d;
      sync_q      <= (state_d == SYNC);
      dv_q        <= code_valid;
      if (code_valid) begin
        data_q <= lut_data;
        k_q    <= lut_k;
        cerr_q <= lut_cerr;
        derr_q <= lut_derr;
        rd_q   <= lut_rd;
      end
    end
  end

`ifdef DEC_ERR_CNT_EN
  logic [15:0] err_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= 16'h0000;
    end else if (code_valid && bad && err_count_q != 16'hFFFF) begin
      err_count_q <= err_count_q + 16'd1;
    end
  end
  assign err_count = err_count_q;
`else
  assign err_count = 16'h0000;
`endif

  assign data_out   = data_q;
  assign k_out      = k_q;
  assign data_valid = dv_q;
  assign code_err   = cerr_q;
  assign disp_err   = derr_q;
  assign rd_out     = rd_q;
  assign sync       = sync_q;

endmodule

// File: tb/tb_dec_8b10b_rx.sv
// Bench for dec_8b10b_rx: a reference built from an 8b/10b encoder model, directed
// link scenarios, an exhaustive 10-bit sweep and randomized streams.
module tb_dec_8b10b_rx;

  localparam int COMMA_CNT = 3;
  localparam int ERR_LIMIT = 4;
  localparam int GOOD_RUN  = 4;
  localparam logic [9:0] K285N = 10'b0011111010;
  localparam logic [9:0] K285P = 10'b1100000101;

  logic        clk = 1'b0;
  logic        rst, code_valid;
  logic [9:0]  code_in;
  logic [7:0]  data_out;
  logic        k_out, data_valid, code_err, disp_err, rd_out, sync;
  logic [15:0] err_count;

  int checks   = 0;
  int failures = 0;

  dec_8b10b_rx #(.COMMA_CNT(COMMA_CNT), .ERR_LIMIT(ERR_LIMIT), .GOOD_RUN(GOOD_RUN)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .data_out(data_out), .k_out(k_out), .data_valid(data_valid), .code_err(code_err),
    .disp_err(disp_err), .rd_out(rd_out), .sync(sync), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // encoder tables in RD- form, abcdei / fghj bit order
  logic [5:0] t6 [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                          6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                          6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                          6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                          6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                          6'b011110, 6'b101011};
  logic [3:0] d4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [3:0] k4 [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  logic [7:0] klist [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                             8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic       tbl_valid [1024];
  logic [7:0] tbl_data  [1024];
  logic       tbl_k     [1024];

  function automatic void encode(input logic [7:0] b, input logic kf, input logic rd,
                                 output logic [9:0] cw, output logic rd_o);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       r;
    x  = b[4:0];
    y  = b[7:5];
    r  = rd;
    c6 = (kf && x == 5'd28) ? 6'b001111 : t6[x];
    if (r && ($countones(c6) != 3 || c6 == 6'b111000)) c6 = ~c6;
    if ($countones(c6) != 3) r = ~r;
    if (kf) c4 = k4[y];
    else if (y == 3'd7 && ((!r && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           (r && (x == 5'd11 || x == 5'd13 || x == 5'd14)))) c4 = 4'b0111;
    else c4 = d4[y];
    if (r && ($countones(c4) != 2 || c4 == 4'b1100 || kf)) c4 = ~c4;
    if ($countones(c4) != 2) r = ~r;
    cw   = {c6, c4};
    rd_o = r;
  endfunction

  function automatic void sub_disp(input int n, input int half, input logic sp_pos,
                                   input logic sp_neg, input logic rd_i,
                                   output logic err, output logic rd_o);
    err  = 1'b0;
    rd_o = rd_i;
    if (n > half || sp_pos) begin
      err  = sp_pos ? !rd_i : rd_i;
      rd_o = 1'b1;
    end else if (n < half || sp_neg) begin
      err  = sp_neg ? rd_i : !rd_i;
      rd_o = 1'b0;
    end
  endfunction

  // reference state
  int          m_state, m_comma, m_err, m_good;
  logic        m_rd, e_dv, e_k, e_cerr, e_derr, e_sync;
  logic [7:0]  e_data;
  logic [15:0] e_ecount;

  task automatic model_step(input logic r, input logic v, input logic [9:0] c);
    logic e1, e2, r6, rn, bad, comma;
    int   n;
    if (r) begin
      m_state = 0; m_comma = 0; m_err = 0; m_good = 0; m_rd = 1'b0;
      e_dv = 1'b0; e_k = 1'b0; e_cerr = 1'b0; e_derr = 1'b0; e_sync = 1'b0;
      e_data = 8'h00; e_ecount = 16'h0000;
      return;
    end
    e_dv = v;
    if (!v) return;
    e_cerr = !tbl_valid[c];
    e_data = e_cerr ? 8'h00 : tbl_data[c];
    e_k    = e_cerr ? 1'b0 : tbl_k[c];
    sub_disp($countones(c[9:4]), 3, c[9:4] == 6'b000111, c[9:4] == 6'b111000, m_rd, e1, r6);
    sub_disp($countones(c[3:0]), 2, c[3:0] == 4'b0011, c[3:0] == 4'b1100, r6, e2, rn);
    e_derr = e1 | e2;
    if (e_cerr) begin
      n  = $countones(c);
      rn = (n > 5) ? 1'b1 : (n < 5) ? 1'b0 : m_rd;
    end
    m_rd  = rn;
    bad   = e_cerr | e_derr;
    comma = !bad && e_k && (e_data == 8'h3C || e_data == 8'hBC || e_data == 8'hFC);
    case (m_state)
      0: if (comma) begin m_comma = 1; m_state = (COMMA_CNT <= 1) ? 2 : 1; m_err = 0; m_good = 0; end
      1: if (bad) m_state = 0;
         else if (comma) begin
           m_comma++;
           if (m_comma >= COMMA_CNT) begin m_state = 2; m_err = 0; m_good = 0; end
         end
      default: if (bad) begin
           m_good = 0;
           m_err++;
           if (m_err >= ERR_LIMIT) m_state = 0;
         end else begin
           m_good++;
           if (m_good >= GOOD_RUN) begin m_good = 0; if (m_err > 0) m_err--; end
         end
    endcase
    e_sync = (m_state == 2);
`ifdef DEC_ERR_CNT_EN
    if (bad && e_ecount != 16'hFFFF) e_ecount = e_ecount + 16'd1;
`endif
  endtask

  task automatic compare_all();
    check_eq("data_valid", data_valid, e_dv);
    check_eq("data_out", data_out, e_data);
    check_eq("k_out", k_out, e_k);
    check_eq("code_err", code_err, e_cerr);
    check_eq("disp_err", disp_err, e_derr);
    check_eq("rd_out", rd_out, m_rd);
    check_eq("sync", sync, e_sync);
    check_eq("err_count", err_count, e_ecount);
  endtask

  task automatic cycle(input logic r, input logic v, input logic [9:0] c);
    rst = r; code_valid = v; code_in = c;
    @(posedge clk);
    model_step(r, v, c);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [9:0]  cw;
    logic        rdo;
    logic [15:0] ec_one;
    int          pct, kind;
    for (int i = 0; i < 1024; i++) begin tbl_valid[i] = 1'b0; tbl_data[i] = 8'h00; tbl_k[i] = 1'b0; end
    for (int r = 0; r < 2; r++) begin
      for (int b = 0; b < 256; b++) begin
        encode(8'(b), 1'b0, r[0], cw, rdo);
        tbl_valid[cw] = 1'b1; tbl_data[cw] = 8'(b); tbl_k[cw] = 1'b0;
      end
      for (int j = 0; j < 12; j++) begin
        encode(klist[j], 1'b1, r[0], cw, rdo);
        tbl_valid[cw] = 1'b1; tbl_data[cw] = klist[j]; tbl_k[cw] = 1'b1;
      end
    end
`ifdef DEC_ERR_CNT_EN
    ec_one = 16'd1;
`else
    ec_one = 16'd0;
`endif

    // reset with a valid word present: word must be dropped
    cycle(1'b1, 1'b1, K285N);
    check_eq("rst_dv", data_valid, 1'b0);
    check_eq("rst_rd", rd_out, 1'b0);
    cycle(1'b0, 1'b1, K285N);
    check_eq("k285n_data", data_out, 8'hBC);
    check_eq("k285n_k", k_out, 1'b1);
    check_eq("k285n_errs", {code_err, disp_err}, 2'b00);
    check_eq("k285n_rd", rd_out, 1'b1);
    cycle(1'b0, 1'b1, 10'b1010101010);
    check_eq("d21_5_data", data_out, 8'hB5);
    check_eq("d21_5_k", k_out, 1'b0);
    check_eq("d21_5_rd", rd_out, 1'b1);
    cycle(1'b0, 1'b0, 10'h3FF);
    check_eq("idle_hold", {data_valid, data_out}, {1'b0, 8'hB5});

    cycle(1'b1, 1'b0, 10'h000);
    cycle(1'b0, 1'b1, K285P);
    check_eq("k285p_data", data_out, 8'hBC);
    check_eq("k285p_derr", disp_err, 1'b1);
    check_eq("k285p_rd", rd_out, 1'b0);

    cycle(1'b1, 1'b0, 10'h000);
    cycle(1'b0, 1'b1, 10'h000);
    check_eq("zero_cerr", code_err, 1'b1);
    check_eq("zero_data", data_out, 8'h00);
    check_eq("zero_errcnt", err_count, ec_one);

    // acquire with three commas, then lose lock on four bad words
    cycle(1'b1, 1'b0, 10'h000);
    cycle(1'b0, 1'b1, K285N);
    cycle(1'b0, 1'b1, K285P);
    check_eq("acq_sync2", sync, 1'b0);
    cycle(1'b0, 1'b1, K285N);
    check_eq("acq_sync3", sync, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 10'h000);
      check_eq("los_sync", sync, (i < 3) ? 1'b1 : 1'b0);
    end

    // reset while locked with RD+
    cycle(1'b1, 1'b0, 10'h000);
    cycle(1'b0, 1'b1, K285N);
    cycle(1'b0, 1'b1, K285P);
    cycle(1'b0, 1'b1, K285N);
    check_eq("pre_rst_state", {sync, rd_out}, 2'b11);
    cycle(1'b1, 1'b0, 10'h000);
    check_eq("mid_rst", {sync, rd_out, data_valid}, 3'b000);
    cycle(1'b0, 1'b1, K285N);
    check_eq("post_rst_k285", {data_out, k_out, code_err, disp_err}, {8'hBC, 3'b100});

    // every 10-bit pattern once
    for (int c = 0; c < 1024; c++) cycle(1'b0, 1'b1, 10'(c));

    // random streams with alternating error density
    for (int i = 0; i < 3000; i++) begin
      pct  = ((i / 400) % 2 == 0) ? 2 : 25;
      kind = $urandom_range(0, 99);
      if ($urandom_range(0, 399) == 0) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), 10'($urandom));
      end else if ($urandom_range(0, 99) < 15) begin
        cycle(1'b0, 1'b0, 10'($urandom));
      end else if (kind < pct / 2) begin
        cycle(1'b0, 1'b1, 10'($urandom));
      end else if (kind < pct) begin
        encode(8'($urandom), 1'b0, ~m_rd, cw, rdo);
        cycle(1'b0, 1'b1, cw);
      end else if (kind < pct + 20) begin
        encode((kind % 3 == 0) ? 8'h3C : (kind % 3 == 1) ? 8'hBC : 8'hFC, 1'b1, m_rd, cw, rdo);
        cycle(1'b0, 1'b1, cw);
      end else if (kind < pct + 25) begin
        encode(klist[$urandom_range(0, 11)], 1'b1, m_rd, cw, rdo);
        cycle(1'b0, 1'b1, cw);
      end else begin
        encode(8'($urandom), 1'b0, m_rd, cw, rdo);
        cycle(1'b0, 1'b1, cw);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_8b10b_rx.md
Name: dec_8b10b_rx

Overview:
- Receive-side 8b/10b decoder, the counterpart of the transmit-side encoder/control ROM.
- Accepts word-aligned 10-bit symbols and outputs the 8-bit value with a K-flag, one cycle later.
- Tracks running disparity and flags code and disparity errors.
- Runs a comma-based link-synchronisation state machine, so downstream logic knows when the lane is trustworthy.

Parameters:
- COMMA_CNT, 3: consecutive valid commas needed in ACQ before declaring SYNC.
- ERR_LIMIT, 4: error credit; when the SYNC-state error count reaches this value, go to LOS.
- GOOD_RUN, 4: consecutive clean words in SYNC that decrement the error count by 1.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- code_in  in  10  received symbol, {a,b,c,d,e,i,f,g,h,j}; code_in[9]=a.
- code_valid  in  1  code_in is valid this cycle; no backpressure.
- data_out  out  8  decoded {H,G,F,E,D,C,B,A}.
- k_out  out  1  symbol was a control (K) character.
- data_valid  out  1  registered copy of code_valid.
- code_err  out  1  code_in is not in the D or K table.
- disp_err  out  1  running-disparity violation.
- rd_out  out  1  running disparity after this word; 0 = RD-, 1 = RD+.
- sync  out  1  link in SYNC state.
- err_count  out  16  saturating error counter (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high. Every output registered. On rst: data_out=0, k_out=0, data_valid=0, code_err=0, disp_err=0, rd=0 (RD-), sync=0, FSM=LOS, internal counters=0. A code_valid in the reset cycle is discarded.
- Latency: exactly 1 clk from code_valid to data_valid. Outputs hold their last value when code_valid=0; data_valid=0 in that case and rd does not change.
- Decode table: all 256 D.x.y codes (both RD columns, including the A7 alternate for D.x.7) plus the 12 K codes K28.0–K28.7, K23.7, K27.7, K29.7, K30.7. Any other pattern: code_err=1, data_out=0, k_out=0.
- Disparity rules, sub-block-wise (6b first, then 4b):
  - Sub-block with more ones, or 6b=000111, or 4b=0011: requires starting rd=- (except 000111/0011, which require +). Ends +.
  - Sub-block with more zeros, or 111000, or 1100: requires starting rd=+ (except 111000/1100, which require -). Ends -.
  - Other balanced sub-blocks: rd unchanged.
  - Any violated requirement sets disp_err=1.
  - 4b rd_start = 6b rd_end. rd_out = 4b rd_end.
- On code_err, rd resyncs from total ones: >5 → 1, <5 → 0, =5 → unchanged. disp_err is also evaluated and reported independently.
- A word is "bad" if code_err or disp_err.
- Sync FSM, evaluated on valid words only:
  - LOS → ACQ on a valid comma (K28.1, K28.5, K28.7 with no error). comma_cnt=1.
  - ACQ: a clean comma increments comma_cnt; a clean non-comma holds; a bad word → LOS. When comma_cnt reaches COMMA_CNT → SYNC, with err_cnt=0 and good_cnt=0.
  - SYNC, bad word: err_cnt+1, good_cnt=0. If err_cnt reaches ERR_LIMIT → LOS.
  - SYNC, clean word: good_cnt+1. When good_cnt reaches GOOD_RUN: good_cnt=0 and err_cnt decrements, floor 0.
  - sync=1 only in SYNC. It updates in the same cycle as data_valid for the triggering word.
- Reset mid-stream returns to LOS with rd=- regardless of state.

Optional Feature:
- Macro DEC_ERR_CNT_EN.
- Defined: err_count increments by 1 for each valid bad word, saturates at 16'hFFFF, and clears only on rst.
- Undefined: counter logic is not built and err_count is tied to 0.

Decomposition:
- Shared package dec_8b10b_pkg holds:
  - constants K28_5_RDN=10'b0011111010 and K28_5_RDP=10'b1100000101;
  - comma detection and K-code constants;
  - FSM state enum {LOS, ACQ, SYNC}.
- Sub-module dec_8b10b_lut: purely combinational. Inputs code_in and rd_in. Outputs data, k, code_err, disp_err, rd_next. The top level holds the rd register, output registers, FSM and counters.

Test Plan:
- After rst, code_in=0011111010 (K28.5 RD-) valid → next cycle data_out=8'hBC, k_out=1, code_err=0, disp_err=0, rd_out=1.
- rd=+, then 1010101010 (D21.5) → data_out=8'hB5, k_out=0, rd_out=1, no errors.
- After rst (rd=-), 1100000101 (K28.5 RD+) → data_out=8'hBC, k_out=1, disp_err=1, rd_out=0.
- 0000000000 valid → code_err=1, data_out=0, rd_out=0; err_count=1 with DEC_ERR_CNT_EN, 0 without.
- Alternating K28.5 RD-/RD+ three times → sync rises with the third data_valid. Then four 0000000000 words with no intervening clean run → sync falls with the fourth.
- Assert rst while in SYNC with rd=+ → next cycle sync=0, rd_out=0, data_valid=0. The subsequent K28.5 RD- decodes cleanly.
